// File: rtl/rapid_pkg.sv
// Shared RAPID-X bus constants and the memory responder's port2 state encoding.
package rapid_pkg;

   localparam int XLEN     = 32;
   localparam int MEM_BE_W = XLEN / 8;

   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_WAIT,
      MEM_RESP
   } mem_state_e;

endpackage

// File: rtl/rapid_mem_array.sv
// Read-first dual-port word array split into byte lanes: port A read-only,
// port B byte-enable read/write. No reset on storage or read registers.
module rapid_mem_array
   import rapid_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096
) (
   input  logic                           clk,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr,
   output logic [XLEN-1:0]                rd_data,
   input  logic                           rw_en,
   input  logic [MEM_BE_W-1:0]            rw_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rw_addr,
   input  logic [XLEN-1:0]                rw_wdata,
   output logic [XLEN-1:0]                rw_rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < MEM_BE_W; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];

         // Reads use the pre-edge contents, so a same-edge write is seen one cycle later.
         always_ff @(posedge clk) begin
            rd_data[8*gi +: 8] <= lane_mem[rd_addr];
            if (rw_en) begin
               rw_rdata[8*gi +: 8] <= lane_mem[rw_addr];
               if (rw_we[gi]) begin
                  lane_mem[rw_addr] <= rw_wdata[8*gi +: 8];
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/rapid_mem_responder.sv
// RAPID-X far-end memory: fixed 1-cycle instruction port and handshaked data port.
// Define RAPID_MEM_WAIT_EN to compile in the WAIT state and WAIT_STATES counter.
module rapid_mem_responder
   import rapid_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int WAIT_STATES = 2
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [XLEN-1:0]     i_port1_address,
   output logic [XLEN-1:0]     o_port1_read_data,
   input  logic [XLEN-1:0]     i_port2_address,
   input  logic                i_port2_read_en,
   input  logic                i_port2_write_en,
   input  logic [MEM_BE_W-1:0] i_port2_byte_en,
   input  logic [XLEN-1:0]     i_port2_write_data,
   output logic [XLEN-1:0]     o_port2_read_data,
   output logic                o_port2_ready,
   output logic                o_port2_error
);

   localparam int AW = $clog2(DEPTH_WORDS);

   generate
      if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
         $error("WAIT_STATES must be within 0..15");
      end
      if ((1 << AW) != DEPTH_WORDS || AW + 2 >= XLEN) begin : g_bad_depth
         $error("DEPTH_WORDS must be a power of two that fits the address");
      end
   endgenerate

   logic [AW-1:0] p1_index, p2_index;
   logic          p1_in_range, p2_in_range;
   logic          p2_req, access, mem_en;
   logic          unused_addr_lsbs;

   assign p1_index         = i_port1_address[AW+1:2];
   assign p2_index         = i_port2_address[AW+1:2];
   assign p1_in_range      = (i_port1_address[XLEN-1:AW+2] == '0);
   assign p2_in_range      = (i_port2_address[XLEN-1:AW+2] == '0);
   assign p2_req           = i_port2_read_en | i_port2_write_en;
   assign unused_addr_lsbs = ^{i_port1_address[1:0], i_port2_address[1:0]};

   mem_state_e state_reg, state_next;

`ifdef RAPID_MEM_WAIT_EN
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);
   logic [3:0] cnt_reg, cnt_next;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_reg <= MEM_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      access     = 1'b0;
      case (state_reg)
         MEM_IDLE: begin
            if (p2_req) begin
               if (WAIT_STATES == 0) begin
                  state_next = MEM_RESP;
                  access     = 1'b1;
               end else begin
                  state_next = MEM_WAIT;
                  cnt_next   = WAIT_INIT;
               end
            end
         end
         MEM_WAIT: begin
            if (cnt_reg == '0) begin
               state_next = MEM_RESP;
               access     = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         MEM_RESP: state_next = MEM_IDLE;
         default:  state_next = MEM_IDLE;
      endcase
   end
`else
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_reg <= MEM_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      access     = 1'b0;
      case (state_reg)
         MEM_IDLE: begin
            if (p2_req) begin
               state_next = MEM_RESP;
               access     = 1'b1;
            end
         end
         MEM_RESP: state_next = MEM_IDLE;
         default:  state_next = MEM_IDLE;
      endcase
   end
`endif

   // The FSM is forced to IDLE while reset is low, so block the array strobe too.
   assign mem_en = access & i_reset;

   logic [XLEN-1:0]     p1_q, p2_q;
   logic [MEM_BE_W-1:0] p2_we;

   assign p2_we = (i_port2_write_en && p2_in_range) ? i_port2_byte_en : '0;

   rapid_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk      (i_clk),
      .rd_addr  (p1_index),
      .rd_data  (p1_q),
      .rw_en    (mem_en),
      .rw_we    (p2_we),
      .rw_addr  (p2_index),
      .rw_wdata (i_port2_write_data),
      .rw_rdata (p2_q)
   );

   logic ready_reg, error_reg, p1_valid_reg, p2_valid_reg;

   // Valid flags zero the unreset BRAM read registers on reset and out-of-range.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         ready_reg    <= 1'b0;
         error_reg    <= 1'b0;
         p1_valid_reg <= 1'b0;
         p2_valid_reg <= 1'b0;
      end else begin
         ready_reg    <= access;
         error_reg    <= access & ~p2_in_range;
         p1_valid_reg <= p1_in_range;
         if (access) begin
            p2_valid_reg <= p2_in_range;
         end
      end
   end

   assign o_port1_read_data = p1_valid_reg ? p1_q : '0;
   assign o_port2_read_data = p2_valid_reg ? p2_q : '0;
   assign o_port2_ready     = ready_reg;
   assign o_port2_error     = error_reg;

endmodule

// File: doc/rapid_mem_responder.md
# rapid_mem_responder

Dual-port memory responder forming the far end of the RAPID-X CPU bus. Serves the CPU's instruction-fetch port (port1) with a fixed one-cycle synchronous read and the CPU memory unit's data port (port2) with a request/ready handshake, optional wait states and byte-enable writes. Backed by a single on-chip word array. Sits between the core's bus and the RAM model or FPGA BRAM in the top-level SoC.

## Interface
Parameters:
- XLEN, 32 (from rapid_pkg): data and address width.
- DEPTH_WORDS, 4096: array depth in XLEN-bit words; power of two.
- WAIT_STATES, 2: extra cycles inserted before each port2 response; 0–15.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_port1_address  in  XLEN  instruction byte address; bits [1:0] ignored.
- o_port1_read_data  out  XLEN  instruction word, registered.
- i_port2_address  in  XLEN  data byte address; bits [1:0] ignored.
- i_port2_read_en  in  1  data read request; held until ready.
- i_port2_write_en  in  1  data write request; held until ready.
- i_port2_byte_en  in  4  per-byte write enables; bit k selects bits [8k+7:8k].
- i_port2_write_data  in  XLEN  store data.
- o_port2_read_data  out  XLEN  load data, valid while o_port2_ready is high.
- o_port2_ready  out  1  one-cycle completion pulse.
- o_port2_error  out  1  out-of-range access; valid with o_port2_ready.

## Operation
- Word index is address[log2(DEPTH_WORDS)+1:2]. An address is in range when all higher bits are 0.
- Port1 reads every cycle, unconditionally:
  - o_port1_read_data = mem[index], registered at each edge.
  - Out-of-range address returns 0.
- Port2 FSM states: IDLE, WAIT, RESP.
  - IDLE: on an edge where read_en or write_en is sampled high, go to WAIT with cnt = WAIT_STATES-1. If WAIT_STATES == 0, go directly to RESP and perform the access.
  - WAIT: cnt decrements each edge. On the edge where cnt == 0, perform the access and go to RESP.
  - RESP: o_port2_ready = 1 for exactly one cycle, then IDLE unconditionally.
  - A request still held in the IDLE cycle after RESP starts a new transaction.
- Access rules:
  - Address, enables and data are sampled on the access edge, not the request edge.
  - Write: only bytes with byte_en set are updated. byte_en == 0 is a legal no-op that still completes.
  - Read: o_port2_read_data is loaded and held until the next access.
  - read_en and write_en both high: treated as a write. read_data returns the pre-write word (read-first).
  - Out of range: write suppressed, read_data = 0, o_port2_error = 1 during RESP.
- Same-word collision on one edge (port2 write, port1 read): port1 returns the old word.
- Reset, asserted at any time:
  - FSM goes to IDLE; cnt, o_port2_ready, o_port2_error, o_port2_read_data and o_port1_read_data are all 0.
  - An in-flight write never commits.
  - Array contents are not cleared.

## Timing
- Port1 latency: 1 cycle (address before edge N → data after edge N).
- Port2 latency: request sampled at edge N → ready high in the cycle after edge N+WAIT_STATES, so WAIT_STATES+1 cycles.
- Back-to-back port2 throughput: one transaction per WAIT_STATES+2 cycles.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- RAPID_MEM_WAIT_EN defined:
  - WAIT state and counter are compiled in.
  - WAIT_STATES is honoured as described above.
- RAPID_MEM_WAIT_EN undefined:
  - WAIT state and counter are removed; WAIT_STATES is ignored.
  - Port2 always behaves as WAIT_STATES == 0: IDLE → RESP, one-cycle latency.

## Structure
- rapid_pkg gains:
  - typedef enum logic [1:0] mem_state_e {MEM_IDLE, MEM_WAIT, MEM_RESP}.
  - Constant MEM_BE_W = XLEN/8.
- Sub-module rapid_mem_array holds the storage:
  - Read-first dual-port array: one read-only port, one byte-enable read/write port.
  - No reset on storage.
  - Maps to BRAM.
- The top level holds the FSM, counter, range check and output registers.

## Test plan
- Reset, then port1 address 0x0 with mem[0]=0x00000013 → o_port1_read_data = 0x00000013 one cycle later. During reset all outputs read 0.
- WAIT_STATES=2: write 0xDEADBEEF to 0x40 with byte_en=4'hF, then read 0x40 → each transaction gives ready 3 cycles after its request; read_data = 0xDEADBEEF, error = 0.
- Byte enables: mem[0x40]=0xDEADBEEF, write 0x11223344 with byte_en=4'b0101 → subsequent read returns 0xDE22BE44.
- Out of range: DEPTH_WORDS=4096, read 0x4000 → ready with error = 1, read_data = 0. Write to 0x4000 → error = 1, and mem[0] (alias index) is unchanged.
- Collision: port1 at 0x80 while port2 writes 0xCAFEF00D to 0x80 on the same edge → port1 returns the old value, and returns 0xCAFEF00D the following cycle.
- Reset mid-WAIT during a write of 0x55 to 0x10 → no ready pulse after reset release, and mem[0x10] keeps its old value.
